receive_buffer: RTL

UART receive path and the counterpart of the transmit buffer on the same SPART-style I/O bus. Samples the serial input RxD with a 16x oversampling tick from the baud generator and assembles frames. A frame is start(0), 8 data bits LSB-first, optional even parity, and stop(1). Each completed byte goes into a one-deep holding register that the CPU reads over the shared iocs/iorw/ioaddr interface.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_sync.sv | 22 ++
 rtl/receive_buffer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit buffers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0]  ADDR_DATA      = 2'b00;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resynchronization into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receive_buffer.sv
// UART receiver: oversampled frame assembly into a one-deep CPU-readable holding register.
module receive_buffer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_t            state, state_nxt;
  logic [SW-1:0]        scnt, scnt_nxt;
  logic [BW-1:0]        bcnt, bcnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_err_q, par_err_nxt;
  logic                 rxs;
  logic                 done_c;
  logic                 rd_c;

  rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RxD),
    .q   (rxs)
  );

  assign rd_c = iocs & iorw & (ioaddr == ADDR_DATA);

  // FSM state, tick/bit counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shift     <= '0;
      par_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      scnt      <= scnt_nxt;
      bcnt      <= bcnt_nxt;
      shift     <= shift_nxt;
      par_err_q <= par_err_nxt;
    end
  end

  // Next-state logic; everything advances only on an oversample tick.
  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    bcnt_nxt    = bcnt;
    shift_nxt   = shift;
    par_err_nxt = par_err_q;
    done_c      = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_nxt = START;
            scnt_nxt  = '0;
          end
        end
        START: begin
          if (scnt == SW'(OVERSAMPLE / 2 - 1)) begin
            if (rxs) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              scnt_nxt  = '0;
              bcnt_nxt  = '0;
            end
          end else begin
            scnt_nxt = scnt + SW'(1);
          end
        end
        DATA: begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_nxt  = '0;
            shift_nxt = {rxs, shift[DATA_BITS-1:1]};
            if (bcnt == BW'(DATA_BITS - 1)) begin
              bcnt_nxt    = '0;
              par_err_nxt = 1'b0;
              state_nxt   = PARITY_EN ? PARITY : STOP;
            end else begin
              bcnt_nxt = bcnt + BW'(1);
            end
          end else begin
            scnt_nxt = scnt + SW'(1);
          end
        end
        PARITY: begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_nxt    = '0;
            par_err_nxt = (^shift) ^ rxs;
            state_nxt   = STOP;
          end else begin
            scnt_nxt = scnt + SW'(1);
          end
        end
        STOP: begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_nxt  = '0;
            done_c    = 1'b1;
            state_nxt = IDLE;
          end else begin
            scnt_nxt = scnt + SW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Holding register and status flags; a read always clears overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (done_c) begin
        rx_data     <= shift;
        parity_err  <= par_err_q;
        framing_err <= ~rxs;
      end
      if (done_c)    rda <= 1'b1;
      else if (rd_c) rda <= 1'b0;
      if (rd_c)                overrun <= 1'b0;
      else if (done_c && rda)  overrun <= 1'b1;
    end
  end

endmodule
